ofdm_symbol_sequencer: RTL and testbench
========================================

Name: ofdm_symbol_sequencer

Overview:
- Sits directly upstream of the FFT demodulator, between the time-synchronised sample stream and its input port.
- Slices the continuous stream into OFDM symbols (CP + FFT_LEN samples) and asserts tlast on the last sample of each symbol.
- Stamps every sample with frame timing metadata {sfn, subframe, symbol, cp_len} so the demodulator knows the CP length and symbol identity.
- Acquires alignment from an SSB sync pulse and free-runs after that, re-aligning on every later pulse.

Parameters:
- IN_DW, 32, complex sample width (im in upper half, re in lower half); passed through unchanged.
- NFFT, 8, log2 FFT size; FFT_LEN = 2**NFFT.
- CP1 (localparam), 20*FFT_LEN/256, long CP, used on symbol 0 of every subframe.
- CP2 (localparam), 18*FFT_LEN/256, normal CP, used on symbols 1..13.
- SFN_MAX (localparam), 1023; SUBFRAMES_PER_FRAME = 20; SYM_PER_SF = 14.
- CPW (localparam), $clog2(CP1).
- SFN_W, SF_W, SYM_W (localparams), $clog2(1023)=10, $clog2(19)=5, $clog2(13)=4.
- USER_W (localparam), SFN_W+SF_W+SYM_W+CPW (24 at defaults).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- s_axis_in_tdata  in  IN_DW  input samples.
- s_axis_in_tvalid  in  1  sample valid; there is no tready, and the block never stalls.
- sync_i  in  1  single-cycle SSB alignment pulse.
- sync_sfn_i  in  SFN_W  SFN of the symbol that starts at the sync pulse.
- sync_subframe_i  in  SF_W  subframe of that symbol.
- sync_symbol_i  in  SYM_W  symbol index of that symbol.
- m_axis_out_tdata  out  IN_DW  registered copy of the input sample.
- m_axis_out_tuser  out  USER_W  {sfn, subframe, symbol, cp_len}, MSB to LSB.
- m_axis_out_tlast  out  1  last sample of the symbol.
- m_axis_out_tvalid  out  1  output valid.
- locked_o  out  1  high while in RUN.

Behaviour:
- Reset, asynchronous on reset_i high:
  - All outputs go to 0; state = IDLE.
  - All counters go to 0, and cp_len reloads to CP1.
  - A reset asserted mid-symbol aborts the symbol immediately; no tlast is emitted for it.
- States:
  - IDLE: input samples are dropped and m_axis_out_tvalid stays 0.
  - On sync_i, load sfn/subframe/symbol from the sync inputs, set sample_cnt = 0, go to RUN.
  - RUN: stays in RUN until reset; there is no exit on error.
- Sync arrival:
  - If s_axis_in_tvalid is high in the sync cycle, that sample is sample 0 of the loaded symbol and is output.
  - If valid is low, the next valid sample is sample 0.
- Symbol length: sym_len = cp_len + FFT_LEN, where cp_len = CP1 if symbol == 0, else CP2.
  - At defaults: 276 samples for symbol 0, 274 for symbols 1..13.
- Counting:
  - sample_cnt advances only on valid input samples.
  - On the sample where sample_cnt == sym_len-1: output tlast=1, reset sample_cnt to 0, then advance the timing.
- Timing advance:
  - symbol increments and wraps 13→0.
  - On that wrap, subframe increments and wraps 19→0.
  - On the subframe wrap, sfn increments and wraps 1023→0.
- Metadata timing:
  - tuser for the whole symbol (CP included) carries that symbol's values.
  - The new cp_len is already present on the first CP sample of the next symbol.
- Latency: exactly 1 clk from input sample to output (registered); tvalid mirrors s_axis_in_tvalid one cycle later.
  - tlast and tuser are meaningful only when tvalid = 1; tlast is 0 whenever tvalid = 0.
- Sync while in RUN:
  - Realign unconditionally, with the same rules as in IDLE; the sync-cycle sample is sample 0 of the loaded symbol.
  - Any partially output symbol is truncated with no tlast.
  - A sync pulse coinciding with a naturally computed symbol boundary overrides the computed next timing.
- Invalid sync values (symbol > 13, or subframe > 19): the pulse is ignored and state is unchanged.

Optional Feature:
- Macro: OFDM_SEQ_SYNC_ERR_CNT_EN.
- Defined:
  - Adds output sync_err_cnt_o [7:0], reset to 0 and saturating at 255.
  - Increments on each accepted sync_i in RUN whose loaded sfn/subframe/symbol differs from the internally predicted values, or that arrives with sample_cnt != 0.
  - The prediction for a sync landing exactly on a boundary is the next symbol's timing.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then 500 valid samples with no sync → tvalid stays 0, locked_o = 0.
- Sync with sfn=5, sf=0, sym=0 on a valid sample, then continuous valid:
  - tlast on output sample 276, with tuser = {5,0,0,20}.
  - Next tlast 274 samples later, with tuser = {5,0,1,18}.
- Sync with sfn=1023, sf=19, sym=13, then 274 valid samples → the next sample has tuser = {0,0,0,20}.
- Valid toggled every other cycle after sync (sym=2) → tlast still on the 274th valid sample; no output while valid = 0.
- Re-sync in RUN:
  - Sync at sample 100 of sym 3 loading sym=7 → the next output sample carries symbol 7 and the sym-3 tlast is never emitted.
  - With the macro defined, sync_err_cnt_o = 1.
- Invalid sync (sym=14) in RUN → ignored, timing continues, error count unchanged.
- reset_i pulsed mid-symbol → outputs 0 within the same cycle (asynchronous), IDLE until the next sync.

Source files
------------

// File: rtl/ofdm_symbol_sequencer.sv
// OFDM symbol slicer ahead of the FFT demodulator: frames the sample stream into CP+FFT symbols with timing metadata.
// Optional sync error counter is enabled by defining OFDM_SEQ_SYNC_ERR_CNT_EN.
module ofdm_symbol_sequencer #(
  parameter int unsigned IN_DW = 32,
  parameter int unsigned NFFT  = 8,
  localparam int unsigned FFT_LEN  = 1 << NFFT,
  localparam int unsigned CP1      = 20 * FFT_LEN / 256,
  localparam int unsigned CP2      = 18 * FFT_LEN / 256,
  localparam int unsigned CPW      = $clog2(CP1),
  localparam int unsigned SFN_W    = $clog2(1023),
  localparam int unsigned SF_W     = $clog2(19),
  localparam int unsigned SYM_W    = $clog2(13),
  localparam int unsigned USER_W   = SFN_W + SF_W + SYM_W + CPW
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  input  logic              sync_i,
  input  logic [SFN_W-1:0]  sync_sfn_i,
  input  logic [SF_W-1:0]   sync_subframe_i,
  input  logic [SYM_W-1:0]  sync_symbol_i,
  output logic [IN_DW-1:0]  m_axis_out_tdata,
  output logic [USER_W-1:0] m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid,
  output logic              locked_o
`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
  ,
  output logic [7:0]        sync_err_cnt_o
`endif
);

  localparam int unsigned SFN_MAX  = 1023;
  localparam int unsigned SF_LAST  = 19;
  localparam int unsigned SYM_LAST = 13;
  localparam int unsigned CNT_W    = $clog2(CP1 + FFT_LEN);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SFN_W-1:0]   sfn_q, sfn_d;
  logic [SF_W-1:0]    sf_q, sf_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [CPW-1:0]     cp_q, cp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_DW-1:0]   tdata_d;
  logic [USER_W-1:0]  tuser_d;
  logic               tlast_d, tvalid_d;
  logic               sync_ok;

  // Out-of-range symbol/subframe pulses are dropped entirely
  assign sync_ok = sync_i && (sync_symbol_i <= SYM_W'(SYM_LAST))
                          && (sync_subframe_i <= SF_W'(SF_LAST));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q           <= IDLE;
      sfn_q             <= '0;
      sf_q              <= '0;
      sym_q             <= '0;
      cp_q              <= CPW'(CP1);
      cnt_q             <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= '0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      locked_o          <= 1'b0;
    end else begin
      state_q           <= state_d;
      sfn_q             <= sfn_d;
      sf_q              <= sf_d;
      sym_q             <= sym_d;
      cp_q              <= cp_d;
      cnt_q             <= cnt_d;
      m_axis_out_tdata  <= tdata_d;
      m_axis_out_tuser  <= tuser_d;
      m_axis_out_tlast  <= tlast_d;
      m_axis_out_tvalid <= tvalid_d;
      locked_o          <= (state_d == RUN);
    end
  end

  // Sync load first, then the sample (if any) is emitted against the resulting timing
  always_comb begin
    state_d  = state_q;
    sfn_d    = sfn_q;
    sf_d     = sf_q;
    sym_d    = sym_q;
    cp_d     = cp_q;
    cnt_d    = cnt_q;
    tdata_d  = m_axis_out_tdata;
    tuser_d  = m_axis_out_tuser;
    tlast_d  = 1'b0;
    tvalid_d = 1'b0;

    if (sync_ok) begin
      state_d = RUN;
      sfn_d   = sync_sfn_i;
      sf_d    = sync_subframe_i;
      sym_d   = sync_symbol_i;
      cp_d    = (sync_symbol_i == '0) ? CPW'(CP1) : CPW'(CP2);
      cnt_d   = '0;
    end

    if ((state_d == RUN) && s_axis_in_tvalid) begin
      tvalid_d = 1'b1;
      tdata_d  = s_axis_in_tdata;
      tuser_d  = {sfn_d, sf_d, sym_d, cp_d};
      if (cnt_d == CNT_W'(cp_d) + CNT_W'(FFT_LEN - 1)) begin
        tlast_d = 1'b1;
        cnt_d   = '0;
        if (sym_d == SYM_W'(SYM_LAST)) begin
          sym_d = '0;
          if (sf_d == SF_W'(SF_LAST)) begin
            sf_d  = '0;
            sfn_d = (sfn_d == SFN_W'(SFN_MAX)) ? '0 : sfn_d + SFN_W'(1);
          end else begin
            sf_d = sf_d + SF_W'(1);
          end
        end else begin
          sym_d = sym_d + SYM_W'(1);
        end
        cp_d = (sym_d == '0) ? CPW'(CP1) : CPW'(CP2);
      end else begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
  logic sync_err;

  // Registered timing at cnt 0 is already the prediction for a boundary-aligned pulse
  assign sync_err = sync_ok && (state_q == RUN) &&
                    ((sync_sfn_i != sfn_q) || (sync_subframe_i != sf_q) ||
                     (sync_symbol_i != sym_q) || (cnt_q != '0));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_err_cnt_o <= '0;
    end else if (sync_err && (sync_err_cnt_o != 8'hFF)) begin
      sync_err_cnt_o <= sync_err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Scoreboard bench for ofdm_symbol_sequencer: a behavioural timing model predicts every output sample.
module tb_ofdm_symbol_sequencer;

  localparam int FFT = 256;
  localparam int CPL = 20;
  localparam int CPN = 18;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] s_axis_in_tdata = '0;
  logic        s_axis_in_tvalid = 1'b0;
  logic        sync_i = 1'b0;
  logic [9:0]  sync_sfn_i = '0;
  logic [4:0]  sync_subframe_i = '0;
  logic [3:0]  sync_symbol_i = '0;
  logic [31:0] m_axis_out_tdata;
  logic [23:0] m_axis_out_tuser;
  logic        m_axis_out_tlast;
  logic        m_axis_out_tvalid;
  logic        locked_o;
`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
  logic [7:0]  sync_err_cnt_o;
`endif

  ofdm_symbol_sequencer dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .sync_i            (sync_i),
    .sync_sfn_i        (sync_sfn_i),
    .sync_subframe_i   (sync_subframe_i),
    .sync_symbol_i     (sync_symbol_i),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tuser  (m_axis_out_tuser),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .locked_o          (locked_o)
`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
    ,
    .sync_err_cnt_o    (sync_err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [23:0] u;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          m_run, m_cnt, m_sfn, m_sf, m_sym, m_err;
  int          out_n;
  int          tl_idx[$];
  logic [23:0] tl_user[$];
  logic [23:0] last_user;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cp_of(input int sym);
    return (sym == 0) ? CPL : CPN;
  endfunction

  function automatic logic [23:0] pack(input int sfn, input int sf, input int sym, input int cp);
    return {10'(sfn), 5'(sf), 4'(sym), 5'(cp)};
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_sfn = 0; m_sf = 0; m_sym = 0; m_err = 0;
    out_n = 0;
    sb.delete();
    tl_idx.delete();
    tl_user.delete();
  endtask

  task automatic clr_tlast();
    tl_idx.delete();
    tl_user.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(m_axis_out_tvalid), 64'(0));
    check({tag, "_tlast"},  64'(m_axis_out_tlast),  64'(0));
    check({tag, "_tuser"},  64'(m_axis_out_tuser),  64'(0));
    check({tag, "_tdata"},  64'(m_axis_out_tdata),  64'(0));
    check({tag, "_locked"}, 64'(locked_o),          64'(0));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    s_axis_in_tvalid = 1'b0;
    sync_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check_zero_outputs("rst");
    reset_i = 1'b0;
  endtask

  // One clock: drive inputs, predict via the model, then compare what the DUT produced
  task automatic cyc(input bit v, input bit s, input int ssfn, input int ssf, input int ssym);
    bit          ev;
    logic [23:0] eu;
    logic [31:0] d;
    exp_t        e;
    d = $urandom;
    ev = 1'b0;
    s_axis_in_tvalid = v;
    s_axis_in_tdata  = d;
    sync_i           = s;
    sync_sfn_i       = 10'(ssfn);
    sync_subframe_i  = 5'(ssf);
    sync_symbol_i    = 4'(ssym);

    if (s && ssym <= 13 && ssf <= 19) begin
      if (m_run != 0 && (ssfn != m_sfn || ssf != m_sf || ssym != m_sym || m_cnt != 0) && m_err < 255)
        m_err++;
      m_run = 1; m_sfn = ssfn; m_sf = ssf; m_sym = ssym; m_cnt = 0;
      out_n = 0;
    end
    if (m_run != 0 && v) begin
      ev = 1'b1;
      eu = pack(m_sfn, m_sf, m_sym, cp_of(m_sym));
      e.d = d; e.u = eu; e.l = 1'b0;
      if (m_cnt == cp_of(m_sym) + FFT - 1) begin
        e.l = 1'b1;
        m_cnt = 0;
        m_sym++;
        if (m_sym == 14) begin
          m_sym = 0;
          m_sf++;
          if (m_sf == 20) begin
            m_sf = 0;
            m_sfn = (m_sfn + 1) % 1024;
          end
        end
      end else begin
        m_cnt++;
      end
      sb.push_back(e);
    end

    @(posedge clk_i);
    #1;
    check("tvalid", 64'(m_axis_out_tvalid), 64'(ev));
    check("locked", 64'(locked_o), 64'(m_run));
`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
    check("err_cnt", 64'(sync_err_cnt_o), 64'(m_err));
`endif
    if (m_axis_out_tvalid) begin
      out_n++;
      last_user = m_axis_out_tuser;
      if (m_axis_out_tlast) begin
        tl_idx.push_back(out_n);
        tl_user.push_back(m_axis_out_tuser);
      end
      check("sb_avail", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tdata", 64'(m_axis_out_tdata), 64'(e.d));
        check("tuser", 64'(m_axis_out_tuser), 64'(e.u));
        check("tlast", 64'(m_axis_out_tlast), 64'(e.l));
      end
    end else begin
      check("tlast_idle", 64'(m_axis_out_tlast), 64'(0));
    end
  endtask

  initial begin
    model_reset();
    last_user = '0;
    do_reset();

    // No sync: everything dropped
    repeat (500) cyc(1, 0, 0, 0, 0);
    check("t1_locked", 64'(locked_o), 64'(0));

    // Acquire at sfn 5 symbol 0; first two symbol ends
    do_reset();
    clr_tlast();
    cyc(1, 1, 5, 0, 0);
    repeat (549) cyc(1, 0, 0, 0, 0);
    check("t2_ntlast", 64'(tl_idx.size()), 64'(2));
    if (tl_idx.size() >= 2) begin
      check("t2_idx0", 64'(tl_idx[0]), 64'(276));
      check("t2_user0", 64'(tl_user[0]), 64'(pack(5, 0, 0, 20)));
      check("t2_idx1", 64'(tl_idx[1]), 64'(550));
      check("t2_user1", 64'(tl_user[1]), 64'(pack(5, 0, 1, 18)));
    end

    // Full wrap of sfn/subframe/symbol
    do_reset();
    clr_tlast();
    cyc(1, 1, 1023, 19, 13);
    repeat (273) cyc(1, 0, 0, 0, 0);
    check("t3_ntlast", 64'(tl_idx.size()), 64'(1));
    if (tl_idx.size() >= 1) check("t3_idx", 64'(tl_idx[0]), 64'(274));
    cyc(1, 0, 0, 0, 0);
    check("t3_wrap_user", 64'(last_user), 64'(pack(0, 0, 0, 20)));

    // Gapped valid
    do_reset();
    clr_tlast();
    cyc(1, 1, 0, 0, 2);
    for (int i = 1; i < 274; i++) begin
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    check("t4_ntlast", 64'(tl_idx.size()), 64'(1));
    if (tl_idx.size() >= 1) check("t4_idx", 64'(tl_idx[0]), 64'(274));

    // Re-sync mid-symbol
    do_reset();
    clr_tlast();
    cyc(1, 1, 0, 0, 3);
    repeat (99) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 7);
    check("t5_sym", 64'(last_user[8:5]), 64'(7));
    repeat (273) cyc(1, 0, 0, 0, 0);
    check("t5_ntlast", 64'(tl_idx.size()), 64'(1));
    if (tl_idx.size() >= 1) check("t5_idx", 64'(tl_idx[0]), 64'(274));
`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
    check("t5_errcnt", 64'(sync_err_cnt_o), 64'(1));
`endif

    // Invalid sync ignored
    cyc(1, 1, 0, 0, 14);
    repeat (10) cyc(1, 0, 0, 0, 0);
    check("t6_locked", 64'(locked_o), 64'(1));
    check("t6_sym", 64'(last_user[8:5]), 64'(8));
`ifdef OFDM_SEQ_SYNC_ERR_CNT_EN
    check("t6_errcnt", 64'(sync_err_cnt_o), 64'(1));
`endif

    // Asynchronous reset mid-symbol
    #2;
    reset_i = 1'b1;
    #1;
    check_zero_outputs("t7_async");
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    repeat (20) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 2, 3, 4);
    repeat (10) cyc(1, 0, 0, 0, 0);
    check("t7_relock_user", 64'(last_user), 64'(pack(2, 3, 4, 18)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
